pwm_capture: RTL and testbench

- Measures an external, asynchronous PWM input in sys_clk ticks and reports, per period, the high time and the period length, with a one-cycle valid strobe.
- Flags a stuck input, high or low, when no edge arrives within a timeout.
- It is the receive-side counterpart to the team's PWM/breathing-LED generators. Loop it back on those outputs for self-check, or use it to read PWM from sensors and fan controllers.

---
 rtl/pwm_pkg.sv | 15 +
 rtl/pwm_edge_det.sv | 60 ++++++
 rtl/pwm_capture.sv | 115 +++++++++++
 tb/tb_pwm_capture.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared PWM definitions: capture FSM state encoding and the default counter
// width / timeout used by the PWM generator and capture blocks.
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } pwm_state_t;

  localparam int          PWM_CNT_W   = 24;
  localparam int unsigned PWM_TIMEOUT = 5_000_000;

endpackage

// File: rtl/pwm_edge_det.sv
// Synchronizes the asynchronous PWM input and detects its edges.
// Optional 3-tap majority glitch filter when PWM_CAPTURE_FILTER_EN is defined.
module pwm_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic pwm_in,
  output logic sig_s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sig_d;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
    end
  end

`ifdef PWM_CAPTURE_FILTER_EN
  // Majority of the last three synchronized samples, registered: single-cycle
  // pulses and gaps never reach the edge detector, at two cycles of latency.
  logic [1:0] hist_q;
  logic       filt_q;
  logic       sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hist_q <= '0;
      filt_q <= 1'b0;
    end else begin
      hist_q <= {hist_q[0], sync_out};
      filt_q <= (sync_out & hist_q[0]) | (sync_out & hist_q[1]) | (hist_q[0] & hist_q[1]);
    end
  end

  assign sig_s = filt_q;
`else
  assign sig_s = sync_q[SYNC_STAGES-1];
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sig_d <= 1'b0;
    end else begin
      sig_d <= sig_s;
    end
  end

  assign rise = sig_s & ~sig_d;
  assign fall = ~sig_s & sig_d;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures high time and period of an asynchronous PWM input and
// flags a stuck input. Build option: PWM_CAPTURE_FILTER_EN (see pwm_edge_det).
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int          CNT_W       = PWM_CNT_W,
  parameter int          SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = PWM_TIMEOUT
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             pwm_in,
  input  logic             meas_en,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             meas_valid,
  output logic             stuck,
  output logic             stuck_level
);

  // Timeout fires on the cycle idle_cnt steps onto TIMEOUT.
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic             sig_s;
  logic             rise;
  logic             fall;
  logic             any_edge;
  logic             timeout;
  pwm_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] high_tmp;
  logic [CNT_W-1:0] idle_cnt;

  pwm_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_det (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .pwm_in   (pwm_in),
    .sig_s    (sig_s),
    .rise     (rise),
    .fall     (fall)
  );

  assign any_edge = rise | fall;
  assign timeout  = !any_edge && (idle_cnt == TIMEOUT_LAST) && (state != IDLE);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      high_tmp    <= '0;
      idle_cnt    <= '0;
      high_cnt    <= '0;
      period_cnt  <= '0;
      meas_valid  <= 1'b0;
      stuck       <= 1'b0;
      stuck_level <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (!meas_en) begin
        state    <= IDLE;
        cnt      <= '0;
        high_tmp <= '0;
        idle_cnt <= '0;
        stuck    <= 1'b0;
      end else begin
        idle_cnt <= any_edge ? '0 : sat_inc(idle_cnt);
        if (any_edge) begin
          stuck <= 1'b0;
        end
        case (state)
          IDLE: state <= ARM;
          ARM: begin
            if (rise) begin
              cnt   <= CNT_W'(1);
              state <= HIGH;
            end
          end
          HIGH: begin
            cnt <= sat_inc(cnt);
            if (fall) begin
              high_tmp <= cnt;
              state    <= LOW;
            end
          end
          LOW: begin
            if (rise) begin
              high_cnt   <= high_tmp;
              period_cnt <= cnt;
              meas_valid <= 1'b1;
              cnt        <= CNT_W'(1);
              state      <= HIGH;
            end else begin
              cnt <= sat_inc(cnt);
            end
          end
          default: state <= IDLE;
        endcase
        // A timeout discards the measurement in progress but keeps the last report.
        if (timeout) begin
          stuck       <= 1'b1;
          stuck_level <= sig_s;
          cnt         <= '0;
          state       <= ARM;
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed testbench for pwm_capture with hand-computed expectations.
// Also valid when built with PWM_CAPTURE_FILTER_EN defined.
module tb_pwm_capture;

  localparam int CNT_W   = 24;
  localparam int TIMEOUT = 1000;
`ifdef PWM_CAPTURE_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  logic             sys_clk;
  logic             sys_rst_n;
  logic             pwm_in;
  logic             meas_en;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic             meas_valid;
  logic             stuck;
  logic             stuck_level;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int validCount = 0;
  int lastHigh = 0;
  int lastPeriod = 0;
  int lastInterval = 0;
  int lastValidCyc = 0;
  int riseCyc = 0;
  int vc0 = 0;
  int duty[3];

  pwm_capture #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(2),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .pwm_in     (pwm_in),
    .meas_en    (meas_en),
    .high_cnt   (high_cnt),
    .period_cnt (period_cnt),
    .meas_valid (meas_valid),
    .stuck      (stuck),
    .stuck_level(stuck_level)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Record every valid strobe: value, cycle, and spacing from the previous one.
  always @(negedge sys_clk) begin
    if (meas_valid) begin
      validCount   <= validCount + 1;
      lastHigh     <= int'(high_cnt);
      lastPeriod   <= int'(period_cnt);
      lastInterval <= cyc - lastValidCyc;
      lastValidCyc <= cyc;
    end
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #2;
    end
  endtask

  // Drive n PWM periods; a non-zero glitchAt drops the input for that one cycle.
  task automatic applyStimulus(input int high, input int period, input int n, input int glitchAt);
    for (int p = 0; p < n; p++) begin
      for (int c = 0; c < period; c++) begin
        pwm_in = ((c < high) && !(glitchAt > 0 && c == glitchAt)) ? 1'b1 : 1'b0;
        if (c == 0) riseCyc = cyc;
        waitCycles(1);
      end
    end
  endtask

  initial begin
`ifdef PWM_CAPTURE_FILTER_EN
    duty[0] = 2;  duty[1] = 25; duty[2] = 48;
`else
    duty[0] = 1;  duty[1] = 25; duty[2] = 49;
`endif
    sys_rst_n = 1'b0;
    pwm_in    = 1'b0;
    meas_en   = 1'b0;
    waitCycles(3);
    checkOutput("rst_high_cnt", int'(high_cnt), 0);
    checkOutput("rst_period_cnt", int'(period_cnt), 0);
    checkOutput("rst_meas_valid", int'(meas_valid), 0);
    checkOutput("rst_stuck", int'(stuck), 0);
    checkOutput("rst_stuck_level", int'(stuck_level), 0);
    sys_rst_n = 1'b1;
    waitCycles(2);
    meas_en = 1'b1;
    waitCycles(5);

    $display("[TB] steady 20/50");
    vc0 = validCount;
    applyStimulus(20, 50, 1, 0);
    checkOutput("first_rise_no_valid", validCount - vc0, 0);
    applyStimulus(20, 50, 1, 0);
    checkOutput("first_valid_count", validCount - vc0, 1);
    checkOutput("first_valid_latency", lastValidCyc - riseCyc, LAT);
    checkOutput("first_high", lastHigh, 20);
    checkOutput("first_period", lastPeriod, 50);
    applyStimulus(20, 50, 4, 0);
    checkOutput("steady_count", validCount - vc0, 5);
    checkOutput("steady_interval", lastInterval, 50);
    checkOutput("steady_high", lastHigh, 20);
    checkOutput("steady_period", lastPeriod, 50);

    $display("[TB] duty sweep");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(duty[i], 50, 3, 0);
      checkOutput($sformatf("sweep_high_%0d", duty[i]), lastHigh, duty[i]);
      checkOutput($sformatf("sweep_period_%0d", duty[i]), lastPeriod, 50);
    end

    $display("[TB] stuck high then low");
    meas_en = 1'b0;
    waitCycles(3);
    meas_en = 1'b1;
    waitCycles(5);
    vc0 = validCount;
    pwm_in = 1'b1;
    waitCycles(TIMEOUT + LAT - 1);
    checkOutput("stuck_not_early", int'(stuck), 0);
    waitCycles(1);
    checkOutput("stuck_high_set", int'(stuck), 1);
    checkOutput("stuck_level_high", int'(stuck_level), 1);
    checkOutput("stuck_no_valid", validCount - vc0, 0);
    pwm_in = 1'b0;
    waitCycles(LAT - 1);
    checkOutput("stuck_hold", int'(stuck), 1);
    waitCycles(1);
    checkOutput("stuck_clear_on_fall", int'(stuck), 0);
    waitCycles(TIMEOUT - 1);
    checkOutput("stuck_low_not_early", int'(stuck), 0);
    waitCycles(1);
    checkOutput("stuck_low_set", int'(stuck), 1);
    checkOutput("stuck_level_low", int'(stuck_level), 0);
    checkOutput("stuck_low_no_valid", validCount - vc0, 0);
    checkOutput("stuck_keeps_high_cnt", int'(high_cnt), duty[2]);

    $display("[TB] meas_en drop mid-high");
    vc0 = validCount;
    pwm_in = 1'b1;
    waitCycles(10);
    meas_en = 1'b0;
    waitCycles(5);
    meas_en = 1'b1;
    waitCycles(10);
    pwm_in = 1'b0;
    waitCycles(25);
    applyStimulus(20, 50, 1, 0);
    checkOutput("reen_one_rise_no_valid", validCount - vc0, 0);
    applyStimulus(20, 50, 1, 0);
    checkOutput("reen_two_rises_valid", validCount - vc0, 1);
    checkOutput("reen_high", lastHigh, 20);
    checkOutput("reen_period", lastPeriod, 50);

    $display("[TB] reset mid-low");
    applyStimulus(30, 50, 2, 0);
    sys_rst_n = 1'b0;
    #1;
    checkOutput("midrst_high_cnt", int'(high_cnt), 0);
    checkOutput("midrst_period_cnt", int'(period_cnt), 0);
    checkOutput("midrst_meas_valid", int'(meas_valid), 0);
    checkOutput("midrst_stuck", int'(stuck), 0);
    checkOutput("midrst_stuck_level", int'(stuck_level), 0);
    waitCycles(3);
    sys_rst_n = 1'b1;
    waitCycles(3);
    vc0 = validCount;
    applyStimulus(20, 50, 3, 0);
    checkOutput("postrst_count", validCount - vc0, 2);
    checkOutput("postrst_high", lastHigh, 20);
    checkOutput("postrst_period", lastPeriod, 50);

`ifdef PWM_CAPTURE_FILTER_EN
    $display("[TB] glitch filter");
    applyStimulus(20, 50, 3, 10);
    checkOutput("glitch_high", lastHigh, 20);
    checkOutput("glitch_period", lastPeriod, 50);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
